// File: rtl/sevenseg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Holds PWM constants, the digit code type and the anode pattern function.
package sevenseg_pkg;

   localparam int PWM_STEPS = 16;
   localparam int PHASE_W   = 4;
   localparam int MAX_DIG   = 16;

   typedef logic [6:0]         digit_t;
   typedef logic [PHASE_W-1:0] phase_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low one-hot anode pattern; bits at or above ndig stay high.
   function automatic logic [MAX_DIG-1:0] onehot_n(
      input logic [3:0] idx,
      input int         ndig
   );
      logic [MAX_DIG-1:0] r;
      r = '1;
      for (int i = 0; i < MAX_DIG; i++) begin
         if (i < ndig && 4'(i) == idx) begin
            r[i] = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sevenseg_ext.sv
// Extended seven-segment decoder, active-low outputs (bit order gfedcba).
// Ports: code (digit_t) in; segs_n, dp_n out.
// code[3:0] hex glyph, code[4] blank glyph, code[5] minus sign, code[6] dp.
module sevenseg_ext
   import sevenseg_pkg::*;
(
   input  digit_t     code,
   output logic [6:0] segs_n,
   output logic       dp_n
);

   always_comb begin
      segs_n = SEG_OFF;
      dp_n   = ~code[6];
      if (code[4]) begin
         segs_n = SEG_OFF;
      end else if (code[5]) begin
         segs_n = 7'h3F;
      end else begin
         case (code[3:0])
            4'h0: segs_n = 7'h40;
            4'h1: segs_n = 7'h79;
            4'h2: segs_n = 7'h24;
            4'h3: segs_n = 7'h30;
            4'h4: segs_n = 7'h19;
            4'h5: segs_n = 7'h12;
            4'h6: segs_n = 7'h02;
            4'h7: segs_n = 7'h78;
            4'h8: segs_n = 7'h00;
            4'h9: segs_n = 7'h10;
            4'hA: segs_n = 7'h08;
            4'hB: segs_n = 7'h03;
            4'hC: segs_n = 7'h46;
            4'hD: segs_n = 7'h21;
            4'hE: segs_n = 7'h06;
            default: segs_n = 7'h0E;
         endcase
      end
   end

endmodule

// File: rtl/sevenseg_scan_timer.sv
// Scan timing chain: prescaler -> PWM phase -> digit index -> blink frames.
// Ports: clk, rst in; phase, idx, frame_start, blink_ph out (all registered).
module sevenseg_scan_timer
   import sevenseg_pkg::*;
#(
   parameter int NDIG         = 8,
   parameter int SUB_DIV      = 6250,
   parameter int BLINK_FRAMES = 64,
   parameter int IDX_W        = $clog2(NDIG)
) (
   input  logic             clk,
   input  logic             rst,
   output phase_t           phase,
   output logic [IDX_W-1:0] idx,
   output logic             frame_start,
   output logic             blink_ph
);

   localparam int PRE_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SUB_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
   localparam phase_t           PH_LAST  = phase_t'(PWM_STEPS - 1);

   logic [PRE_W-1:0] presc;
   logic [BLK_W-1:0] fcnt;
   logic             sub_tick;
   logic             ph_wrap;
   logic             idx_wrap;

   assign sub_tick = (presc == PRE_LAST);
   assign ph_wrap  = sub_tick && (phase == PH_LAST);
   assign idx_wrap = ph_wrap && (idx == IDX_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc       <= '0;
         phase       <= '0;
         idx         <= '0;
         fcnt        <= '0;
         blink_ph    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         presc <= sub_tick ? '0 : presc + 1'b1;
         if (sub_tick) begin
            phase <= phase + 1'b1;
         end
         if (ph_wrap) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end
         // Registered so the pulse lines up with the first idx = 0 cycle.
         frame_start <= idx_wrap;
         if (frame_start) begin
            if (fcnt == BLK_LAST) begin
               fcnt     <= '0;
               blink_ph <= ~blink_ph;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sevenseg_scan_ctl.sv
// Multi-digit seven-segment scan controller with double-buffered updates,
// PWM brightness, blink, blanking and a dark phase 0 against ghosting.
// Ports: clk, rst, d, dp_en, blank, blink, bright, load in;
//        segs_n, dp_n, an_n, frame_start out (all registered).
module sevenseg_scan_ctl
   import sevenseg_pkg::*;
#(
   parameter int NDIG         = 8,
   parameter int SUB_DIV      = 6250,
   parameter int BLINK_FRAMES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NDIG*7-1:0] d,
   input  logic [NDIG-1:0]   dp_en,
   input  logic [NDIG-1:0]   blank,
   input  logic [NDIG-1:0]   blink,
   input  logic [3:0]        bright,
   input  logic              load,
   output logic [6:0]        segs_n,
   output logic              dp_n,
   output logic [NDIG-1:0]   an_n,
   output logic              frame_start
);

   localparam int IDX_W = $clog2(NDIG);

   phase_t           phase;
   logic [IDX_W-1:0] idx;
   logic             blink_ph;

   sevenseg_scan_timer #(
      .NDIG         (NDIG),
      .SUB_DIV      (SUB_DIV),
      .BLINK_FRAMES (BLINK_FRAMES),
      .IDX_W        (IDX_W)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .phase       (phase),
      .idx         (idx),
      .frame_start (frame_start),
      .blink_ph    (blink_ph)
   );

   logic [NDIG*7-1:0] sh_d,     ac_d;
   logic [NDIG-1:0]   sh_dp,    ac_dp;
   logic [NDIG-1:0]   sh_blank, ac_blank;
   logic [NDIG-1:0]   sh_blink, ac_blink;
   logic [3:0]        sh_bright, ac_bright;

   // The swap reads the shadow before a same-cycle load lands in it,
   // so such a load waits for the following frame boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_d      <= '0;
         sh_dp     <= '0;
         sh_blank  <= '1;
         sh_blink  <= '0;
         sh_bright <= 4'hF;
         ac_d      <= '0;
         ac_dp     <= '0;
         ac_blank  <= '1;
         ac_blink  <= '0;
         ac_bright <= 4'hF;
      end else begin
         if (frame_start) begin
            ac_d      <= sh_d;
            ac_dp     <= sh_dp;
            ac_blank  <= sh_blank;
            ac_blink  <= sh_blink;
            ac_bright <= sh_bright;
         end
         if (load) begin
            sh_d      <= d;
            sh_dp     <= dp_en;
            sh_blank  <= blank;
            sh_blink  <= blink;
            sh_bright <= bright;
         end
      end
   end

   digit_t     code;
   logic [6:0] dec_segs;
   logic       dec_dp;
   logic       lit;

   assign code = ac_d[7*int'(idx) +: 7];

   sevenseg_ext u_dec (
      .code   (code),
      .segs_n (dec_segs),
      .dp_n   (dec_dp)
   );

   // Phase 0 is never lit, so the anode handover always has a dark gap.
   assign lit = (phase != '0)
             && (phase <= ac_bright)
             && !ac_blank[idx]
             && !(ac_blink[idx] && blink_ph);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         segs_n <= SEG_OFF;
         dp_n   <= 1'b1;
         an_n   <= '1;
      end else begin
         segs_n <= lit ? dec_segs : SEG_OFF;
         dp_n   <= lit ? (dec_dp & ~ac_dp[idx]) : 1'b1;
         an_n   <= lit ? NDIG'(onehot_n(4'(idx), NDIG)) : '1;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
// Self-checking bench for sevenseg_scan_ctl (NDIG=4, SUB_DIV=2, BLINK_FRAMES=2).
// Time-indexed reference model plus directed and random load scenarios.
module tb_sevenseg_scan_ctl;

   localparam int NDIG = 4;
   localparam int SD   = 2;
   localparam int BF   = 2;
   localparam int SLOT = 16 * SD;
   localparam int FL   = SLOT * NDIG;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [27:0] d = '0;
   logic [3:0]  dp_en = '0;
   logic [3:0]  blank = '0;
   logic [3:0]  blink = '0;
   logic [3:0]  bright = '0;
   logic        load = 1'b0;
   logic [6:0]  segs_n;
   logic        dp_n;
   logic [3:0]  an_n;
   logic        frame_start;

   int vecs = 0;
   int errs = 0;

   sevenseg_scan_ctl #(
      .NDIG         (NDIG),
      .SUB_DIV      (SD),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .d           (d),
      .dp_en       (dp_en),
      .blank       (blank),
      .blink       (blink),
      .bright      (bright),
      .load        (load),
      .segs_n      (segs_n),
      .dp_n        (dp_n),
      .an_n        (an_n),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Active-high glyphs, gfedcba.
   function automatic logic [6:0] font_n(input logic [6:0] c);
      logic [6:0] hexf [16];
      hexf = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      if (c[4]) return 7'h7F;
      if (c[5]) return ~7'h40;
      return ~hexf[c[3:0]];
   endfunction

   // Model: state index m_n counts clock edges since reset release.
   logic [27:0] m_sd, m_ad;
   logic [3:0]  m_sdp, m_adp, m_sbl, m_abl, m_sbk, m_abk, m_sbr, m_abr;
   int          m_n = 0;
   bit          have_exp = 0;
   logic [6:0]  e_segs;
   logic        e_dp;
   logic [3:0]  e_an;
   logic        e_fs;

   always @(posedge clk) begin
      if (rst) begin
         m_sd = '0;  m_ad = '0;
         m_sdp = '0; m_adp = '0;
         m_sbl = '1; m_abl = '1;
         m_sbk = '0; m_abk = '0;
         m_sbr = 4'hF; m_abr = 4'hF;
         m_n = 0;
         have_exp = 0;
      end else begin
         int ph, ix, f, bp;
         bit on;
         logic [6:0] c;
         ph = (m_n / SD) % 16;
         ix = (m_n / SLOT) % NDIG;
         f  = m_n / FL;
         bp = (f / BF) % 2;
         on = (ph != 0) && (ph <= int'(m_abr)) && !m_abl[ix]
              && !(m_abk[ix] && bp == 1);
         c = m_ad[ix*7 +: 7];
         e_an   = on ? ~(4'b0001 << ix) : 4'hF;
         e_segs = on ? font_n(c) : 7'h7F;
         e_dp   = on ? ~(c[6] | m_adp[ix]) : 1'b1;
         e_fs   = ((m_n + 1) % FL) == 0;
         if (m_n > 0 && (m_n % FL) == 0) begin
            m_ad = m_sd; m_adp = m_sdp; m_abl = m_sbl;
            m_abk = m_sbk; m_abr = m_sbr;
         end
         if (load) begin
            m_sd = d; m_sdp = dp_en; m_sbl = blank;
            m_sbk = blink; m_sbr = bright;
         end
         m_n++;
         have_exp = 1;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_an", 32'(an_n), 32'hF);
         chk("rst_segs", 32'(segs_n), 32'h7F);
         chk("rst_dp", 32'(dp_n), 32'h1);
         chk("rst_fs", 32'(frame_start), 32'h0);
      end else if (have_exp) begin
         chk("an", 32'(an_n), 32'(e_an));
         chk("segs", 32'(segs_n), 32'(e_segs));
         chk("dp", 32'(dp_n), 32'(e_dp));
         chk("fs", 32'(frame_start), 32'(e_fs));
      end
   end

   int         lo [4];
   int         seg_bad;
   int         dp_bad;
   logic [6:0] want_seg [4];
   logic [3:0] want_dp_on;

   task automatic scan(input int cyc);
      for (int i = 0; i < 4; i++) lo[i] = 0;
      seg_bad = 0;
      dp_bad  = 0;
      for (int k = 0; k < cyc; k++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (an_n[i] == 1'b0) begin
               lo[i]++;
               if (segs_n != want_seg[i]) seg_bad++;
               if (dp_n != !want_dp_on[i]) dp_bad++;
            end
         end
      end
   endtask

   task automatic wait_phase(input int m);
      int g;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while ((m_n % FL) != m && g < 4 * FL);
      if ((m_n % FL) != m) begin
         vecs++;
         errs++;
         $display("FAIL wait_phase: got %0d want %0d", m_n % FL, m);
      end
   endtask

   task automatic do_load();
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      int k, lit_cnt, f, exp3;

      want_seg = '{7'h40, 7'h79, 7'h24, 7'h30};
      want_dp_on = 4'b0000;

      repeat (3) @(negedge clk);
      #2 rst = 1'b0;

      // Idle after reset: dark, first frame_start after 128 cycles.
      k = 0; lit_cnt = 0;
      do begin
         @(negedge clk);
         k++;
         if (an_n != 4'hF || segs_n != 7'h7F) lit_cnt++;
      end while (!frame_start && k < 400);
      chk("first_fs", 32'(k), 32'd128);
      chk("idle_dark", 32'(lit_cnt), 32'd0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!frame_start && k < 400);
      chk("fs_period", 32'(k), 32'd128);

      // Full brightness, digits 0..3.
      repeat (5) @(negedge clk);
      d = {7'd3, 7'd2, 7'd1, 7'd0};
      blank = 4'b0000; dp_en = 4'b0000; blink = 4'b0000; bright = 4'd15;
      do_load();
      wait_phase(2);
      scan(FL);
      for (int i = 0; i < 4; i++) chk($sformatf("b15_lo%0d", i), 32'(lo[i]), 32'd30);
      chk("b15_segs", 32'(seg_bad), 32'd0);

      bright = 4'd4;
      do_load();
      wait_phase(2);
      scan(FL);
      for (int i = 0; i < 4; i++) chk($sformatf("b4_lo%0d", i), 32'(lo[i]), 32'd8);

      bright = 4'd0;
      do_load();
      wait_phase(2);
      scan(FL);
      chk("b0_lo", 32'(lo[0] + lo[1] + lo[2] + lo[3]), 32'd0);

      // Blank digit 1, decimal point on digit 0.
      bright = 4'd15; blank = 4'b0010; dp_en = 4'b0001;
      want_dp_on = 4'b0001;
      do_load();
      wait_phase(2);
      scan(FL);
      chk("blank_lo1", 32'(lo[1]), 32'd0);
      chk("blank_lo0", 32'(lo[0]), 32'd30);
      chk("dp_bits", 32'(dp_bad), 32'd0);
      want_dp_on = 4'b0000;

      // Blink digit 3: two frames lit, two dark.
      blank = 4'b0000; dp_en = 4'b0000; blink = 4'b1000;
      do_load();
      wait_phase(2);
      for (int w = 0; w < 4; w++) begin
         f = (m_n - 2) / FL;
         exp3 = (((f / BF) % 2) == 1) ? 0 : 30;
         scan(FL);
         chk($sformatf("blink_w%0d", w), 32'(lo[3]), 32'(exp3));
         chk($sformatf("blink_d0_w%0d", w), 32'(lo[0]), 32'd30);
      end

      // Load coincident with frame_start, then another load 10 cycles later.
      blink = 4'b0000;
      wait_phase(0);
      d = {4{7'h08}};
      do_load();
      repeat (9) @(negedge clk);
      d = {4{7'h01}};
      do_load();
      wait_phase(2);
      want_seg = '{7'h79, 7'h79, 7'h79, 7'h79};
      scan(FL);
      chk("dbl_segs", 32'(seg_bad), 32'd0);
      chk("dbl_lo2", 32'(lo[2]), 32'd30);

      // Async reset mid-slot.
      wait_phase(40);
      chk("pre_rst_an", 32'(an_n), 32'b1101);
      #2 rst = 1'b1;
      #1 chk("async_an", 32'(an_n), 32'hF);
      chk("async_segs", 32'(segs_n), 32'h7F);
      @(negedge clk);
      #2 rst = 1'b0;
      scan(FL + 10);
      chk("post_rst_dark", 32'(lo[0] + lo[1] + lo[2] + lo[3]), 32'd0);

      // Random loads at random times.
      for (int r = 0; r < 20; r++) begin
         d      = 28'($urandom);
         dp_en  = 4'($urandom);
         blank  = 4'($urandom) & 4'($urandom);
         blink  = 4'($urandom) & 4'($urandom);
         bright = 4'($urandom);
         do_load();
         repeat ($urandom_range(20, 300)) @(negedge clk);
      end
      repeat (2 * FL) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
